// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the reduced RISC-V multi-cycle controller.
// Opcodes, ALU operation encodings and the FSM state type.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_ADDI = 7'b0010011;
  localparam logic [6:0] OPC_BNE  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_CMP = 3'b111;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXEC_ADDI = 3'd2,
    WB        = 3'd3,
    EXEC_BNE  = 3'd4,
    HALT      = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for addi/bne: fetch handshake, decode,
// execute and writeback strobes, retire counter, sticky illegal halt.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          instr_opcode,
  input  logic                EQ,
  input  logic                imem_ack,
  output logic                imem_req,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic [2:0]          ALUctrl,
  output logic                ALUsrc,
  output logic                ImmSrc,
  output logic                PCsrc,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired,
  output logic [2:0]          state
);

  ctrl_state_t state_q, state_nx;
  logic req_raw, irw_raw, pcw_raw, rgw_raw, pcs_raw;
  logic retire, set_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= state_nx;
      if (set_illegal) illegal <= 1'b1;
      if (retire) retired <= retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    state_nx    = state_q;
    req_raw     = 1'b0;
    irw_raw     = 1'b0;
    pcw_raw     = 1'b0;
    rgw_raw     = 1'b0;
    pcs_raw     = 1'b0;
    ALUctrl     = ALU_ADD;
    ALUsrc      = 1'b0;
    ImmSrc      = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    case (state_q)
      FETCH: begin
        req_raw = 1'b1;
        if (imem_ack) begin
          irw_raw  = 1'b1;
          state_nx = DECODE;
        end
      end
      DECODE: begin
        if (instr_opcode == OPC_ADDI) begin
          state_nx = EXEC_ADDI;
        end else if (instr_opcode == OPC_BNE) begin
          state_nx = EXEC_BNE;
        end else begin
          state_nx    = HALT;
          set_illegal = 1'b1;
        end
      end
      EXEC_ADDI: begin
        ALUsrc   = 1'b1;
        ImmSrc   = 1'b1;
        state_nx = WB;
      end
      WB: begin
        ALUsrc   = 1'b1;
        ImmSrc   = 1'b1;
        rgw_raw  = 1'b1;
        pcw_raw  = 1'b1;
        retire   = 1'b1;
        state_nx = FETCH;
      end
      EXEC_BNE: begin
        ALUctrl  = ALU_CMP;
        pcw_raw  = 1'b1;
        pcs_raw  = ~EQ;
        retire   = 1'b1;
        state_nx = FETCH;
      end
      HALT: state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  // Reset overrides every strobe in the cycle it is asserted
  assign imem_req = req_raw & ~rst;
  assign IRWrite  = irw_raw & ~rst;
  assign PCWrite  = pcw_raw & ~rst;
  assign RegWrite = rgw_raw & ~rst;
  assign PCsrc    = pcs_raw & ~rst;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios then random
// stimulus, checked every cycle against an instruction-level model.
module tb_multicycle_control;

  localparam int RW = 4;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] BNE  = 7'b1100011;
  localparam logic [6:0] RTYP = 7'b0110011;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    instr_opcode;
  logic          EQ;
  logic          imem_ack;
  logic          imem_req, IRWrite, PCWrite, RegWrite;
  logic [2:0]    ALUctrl;
  logic          ALUsrc, ImmSrc, PCsrc, illegal;
  logic [RW-1:0] retired;
  logic [2:0]    state;

  int n_chk = 0;
  int n_err = 0;

  // Model: where we are inside the current instruction
  int m_pos;
  bit m_bne;
  bit m_halt;
  bit m_ill;
  int m_ret;

  multicycle_control #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .instr_opcode(instr_opcode), .EQ(EQ),
    .imem_ack(imem_ack), .imem_req(imem_req), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUctrl(ALUctrl),
    .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .PCsrc(PCsrc),
    .illegal(illegal), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_bne = 0; m_halt = 0; m_ill = 0; m_ret = 0;
  endtask

  task automatic cycle(input bit r, input bit ack,
                       input logic [6:0] opc, input bit eq);
    bit exe_add, wb, exe_bne, fetch;
    int exp_st;
    rst = r; imem_ack = ack; instr_opcode = opc; EQ = eq;
    fetch   = !m_halt && m_pos == 0;
    exe_add = !m_halt && !m_bne && m_pos == 2;
    wb      = !m_halt && !m_bne && m_pos == 3;
    exe_bne = !m_halt && m_bne && m_pos == 2;
    if (m_halt) exp_st = 5;
    else if (m_pos < 2) exp_st = m_pos;
    else if (m_bne) exp_st = 4;
    else exp_st = m_pos;
    @(negedge clk);
    chk("state", 32'(state), 32'(exp_st));
    chk("imem_req", 32'(imem_req), 32'(!r && fetch));
    chk("IRWrite", 32'(IRWrite), 32'(!r && fetch && ack));
    chk("RegWrite", 32'(RegWrite), 32'(!r && wb));
    chk("PCWrite", 32'(PCWrite), 32'(!r && (wb || exe_bne)));
    chk("PCsrc", 32'(PCsrc), 32'(!r && exe_bne && !eq));
    chk("ALUctrl", 32'(ALUctrl), exe_bne ? 32'd7 : 32'd0);
    chk("ALUsrc", 32'(ALUsrc), 32'(exe_add || wb));
    chk("ImmSrc", 32'(ImmSrc), 32'(exe_add || wb));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("retired", 32'(retired), 32'(m_ret % (1 << RW)));
    @(posedge clk);
    if (r) model_reset();
    else if (!m_halt) begin
      case (m_pos)
        0: if (ack) m_pos = 1;
        1: if (opc == ADDI) begin m_bne = 0; m_pos = 2; end
           else if (opc == BNE) begin m_bne = 1; m_pos = 2; end
           else begin m_halt = 1; m_ill = 1; end
        2: if (m_bne) begin m_ret++; m_pos = 0; end
           else m_pos = 3;
        default: begin m_ret++; m_pos = 0; end
      endcase
    end
    #1;
  endtask

  task automatic run_instr(input logic [6:0] opc, input bit eq);
    int n;
    n = (opc == BNE) ? 3 : 4;
    for (int i = 0; i < n; i++) cycle(0, 1, opc, eq);
  endtask

  initial begin
    rst = 1; imem_ack = 0; instr_opcode = '0; EQ = 0;
    @(posedge clk); #1;
    model_reset();
    cycle(1, 1, ADDI, 0);
    // addi with ack held
    run_instr(ADDI, 0);
    chk("retired_after_addi", 32'(retired), 32'd1);
    run_instr(BNE, 0);
    run_instr(BNE, 1);
    // fetch stall
    for (int i = 0; i < 5; i++) cycle(0, 0, ADDI, 0);
    run_instr(ADDI, 1);
    // counter wrap: 17 more addi
    cycle(1, 0, ADDI, 0);
    for (int i = 0; i < 17; i++) run_instr(ADDI, 0);
    chk("retired_wrap", 32'(retired), 32'd1);
    // illegal opcode and halt
    cycle(0, 1, RTYP, 0);
    cycle(0, 1, RTYP, 0);
    for (int i = 0; i < 12; i++) cycle(0, 1, ADDI, 1);
    chk("halt_state", 32'(state), 32'd5);
    cycle(1, 1, ADDI, 0);
    chk("illegal_cleared", 32'(illegal), 32'd0);
    // reset while in WB
    for (int i = 0; i < 3; i++) cycle(0, 1, ADDI, 0);
    cycle(1, 1, ADDI, 0);
    chk("wb_reset_retired", 32'(retired), 32'd0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [6:0] opc;
      int sel;
      sel = $urandom_range(0, 19);
      opc = sel < 9 ? ADDI : sel < 18 ? BNE : 7'($urandom);
      cycle($urandom_range(0, 39) == 0, 1'($urandom), opc, 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
